// File: rtl/vga_hsync_timing.sv
// Horizontal timing stage of the VGA controller.
// Divides clk_i into a one-cycle pixel tick, runs the horizontal pixel counter,
// pulses line_end_o once per line to enable the external vertical counter,
// and decodes h_count together with the returned v_count into sync, blanking
// and visible pixel coordinates. All outputs are registered.
//
// Ports:
//   clk_i       system clock
//   reset_i     synchronous active-high reset
//   v_count_i   current line number from the vertical counter
//   pix_tick_o  one-cycle pulse per pixel period
//   h_count_o   horizontal pixel counter, 0..H_TOTAL-1
//   line_end_o  one-cycle pulse in the cycle after h_count wraps to 0
//   hsync_o     horizontal sync, active level SYNC_POL
//   vsync_o     vertical sync, active level SYNC_POL
//   video_on_o  high inside the visible window
//   pixel_x_o   visible column, 0 outside the window
//   pixel_y_o   visible row, 0 outside the window
module vga_hsync_timing #(
  parameter int unsigned PIX_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] v_count_i,
  output logic       pix_tick_o,
  output logic [9:0] h_count_o,
  output logic       line_end_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       video_on_o,
  output logic [9:0] pixel_x_o,
  output logic [9:0] pixel_y_o
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned DivW    = $clog2(PIX_DIV);

  localparam logic [DivW-1:0] DivLast = DivW'(PIX_DIV - 1);
  localparam logic [9:0] HLast       = 10'(H_TOTAL - 1);
  localparam logic [9:0] HDisp       = 10'(H_DISPLAY);
  localparam logic [9:0] HSyncStart  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HSyncEnd    = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VDisp       = 10'(V_DISPLAY);
  localparam logic [9:0] VSyncStart  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VSyncEnd    = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic       SyncAct     = (SYNC_POL != 0);

  logic [DivW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic [9:0]      h_q, h_d;
  logic            line_end_q, line_end_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            video_on_q, video_on_d;
  logic [9:0]      px_q, px_d;
  logic [9:0]      py_q, py_d;

  always_comb begin
    div_d      = (div_q == DivLast) ? '0 : div_q + 1'b1;
    tick_d     = (div_q == DivLast);
    h_d        = h_q;
    line_end_d = 1'b0;
    if (tick_q) begin
      h_d        = (h_q == HLast) ? '0 : h_q + 10'd1;
      // Registered here so the pulse lands in the first cycle showing h_count == 0.
      line_end_d = (h_q == HLast);
    end

    // Decode uses the registered count, so every output lags h_count by one cycle.
    hsync_d    = ((h_q >= HSyncStart) && (h_q < HSyncEnd)) ? SyncAct : ~SyncAct;
    vsync_d    = ((v_count_i >= VSyncStart) && (v_count_i < VSyncEnd)) ? SyncAct : ~SyncAct;
    video_on_d = (h_q < HDisp) && (v_count_i < VDisp);
    px_d       = video_on_d ? h_q : '0;
    py_d       = video_on_d ? v_count_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      h_q        <= '0;
      line_end_q <= 1'b0;
      hsync_q    <= ~SyncAct;
      vsync_q    <= ~SyncAct;
      video_on_q <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      h_q        <= h_d;
      line_end_q <= line_end_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      px_q       <= px_d;
      py_q       <= py_d;
    end
  end

  assign pix_tick_o = tick_q;
  assign h_count_o  = h_q;
  assign line_end_o = line_end_q;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign video_on_o = video_on_q;
  assign pixel_x_o  = px_q;
  assign pixel_y_o  = py_q;

endmodule

// File: tb/tb_vga_hsync_timing.sv
module tb_vga_hsync_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance: PIX_DIV=4, active-low syncs.
  logic       rst;
  logic [9:0] vc;
  logic       tick, le, hs, vs, von;
  logic [9:0] hc, px, py;

  // Second instance: PIX_DIV=2, active-high syncs.
  logic       rst_p;
  logic [9:0] vcp;
  logic       tick_p, le_p, hs_p, vs_p, von_p;
  logic [9:0] hc_p, px_p, py_p;

  vga_hsync_timing #(
    .PIX_DIV(4), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .SYNC_POL(0)
  ) u_dut (
    .clk_i(clk), .reset_i(rst), .v_count_i(vc), .pix_tick_o(tick), .h_count_o(hc),
    .line_end_o(le), .hsync_o(hs), .vsync_o(vs), .video_on_o(von),
    .pixel_x_o(px), .pixel_y_o(py)
  );

  vga_hsync_timing #(
    .PIX_DIV(2), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2), .SYNC_POL(1)
  ) u_pol (
    .clk_i(clk), .reset_i(rst_p), .v_count_i(vcp), .pix_tick_o(tick_p), .h_count_o(hc_p),
    .line_end_o(le_p), .hsync_o(hs_p), .vsync_o(vs_p), .video_on_o(von_p),
    .pixel_x_o(px_p), .pixel_y_o(py_p)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for the tick cycle in which h_count shows prev.
  task automatic wait_tick_at(input logic [9:0] prev, input string name);
    bit found = 0;
    for (int i = 0; i < 4000; i++) begin
      if (tick === 1'b1 && hc === prev) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for h_count %0d", name, prev);
    end
  endtask

  // Checks the divider/counter start-up pattern after reset is released at a negedge.
  task automatic check_restart(input string tag);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk({tag, "_tick"}, tick, (k % 4 == 0));
      chk({tag, "_le"}, le, 1'b0);
      if (k == 3) chk({tag, "_h3"}, hc, 0);
      if (k == 4) chk({tag, "_h4"}, hc, 0);
      if (k == 5) chk({tag, "_h5"}, hc, 1);
      if (k == 9) chk({tag, "_h9"}, hc, 2);
    end
  endtask

  typedef struct {
    logic [9:0] v;
    logic [9:0] h;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [9:0] py;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, hs_low, wide;
    logic le_prev;
    logic [9:0] prev;

    //           v       h       hs  vs  von px      py
    tbl[0]  = '{10'd100, 10'd0,   1, 1, 1, 10'd0,   10'd100};
    tbl[1]  = '{10'd100, 10'd5,   1, 1, 1, 10'd5,   10'd100};
    tbl[2]  = '{10'd100, 10'd639, 1, 1, 1, 10'd639, 10'd100};
    tbl[3]  = '{10'd100, 10'd640, 1, 1, 0, 10'd0,   10'd0};
    tbl[4]  = '{10'd100, 10'd655, 1, 1, 0, 10'd0,   10'd0};
    tbl[5]  = '{10'd100, 10'd656, 0, 1, 0, 10'd0,   10'd0};
    tbl[6]  = '{10'd100, 10'd751, 0, 1, 0, 10'd0,   10'd0};
    tbl[7]  = '{10'd100, 10'd752, 1, 1, 0, 10'd0,   10'd0};
    tbl[8]  = '{10'd479, 10'd799, 1, 1, 0, 10'd0,   10'd0};
    tbl[9]  = '{10'd479, 10'd10,  1, 1, 1, 10'd10,  10'd479};
    tbl[10] = '{10'd480, 10'd20,  1, 1, 0, 10'd0,   10'd0};
    tbl[11] = '{10'd490, 10'd30,  1, 0, 0, 10'd0,   10'd0};
    tbl[12] = '{10'd491, 10'd700, 0, 0, 0, 10'd0,   10'd0};
    tbl[13] = '{10'd492, 10'd40,  1, 1, 0, 10'd0,   10'd0};
    tbl[14] = '{10'd524, 10'd50,  1, 1, 0, 10'd0,   10'd0};
    tbl[15] = '{10'd489, 10'd60,  1, 1, 0, 10'd0,   10'd0};

    rst   = 1'b1;
    vc    = 10'd0;
    rst_p = 1'b1;
    vcp   = 10'd490;

    // Reset held for 3 clocks.
    repeat (3) @(negedge clk);
    chk("rst_h", hc, 0);
    chk("rst_tick", tick, 0);
    chk("rst_le", le, 0);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 1);
    chk("rst_von", von, 0);
    chk("rst_px", px, 0);
    chk("rst_py", py, 0);
    rst = 1'b0;
    check_restart("pwrup");

    // Line period with v_count = 0: wrap at clock 3201, next at 6401.
    first   = 0;
    second  = 0;
    hs_low  = 0;
    wide    = 0;
    le_prev = le;
    for (int k = 13; k <= 6402; k++) begin
      @(negedge clk);
      if (le && !le_prev) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (le && le_prev) wide++;
      if (k == 3200) chk("line_h799", hc, 799);
      if (k == 3201) chk("line_h0", hc, 0);
      if (k >= 3201 && k <= 6400 && !hs) hs_low++;
      le_prev = le;
    end
    chk("line_first", first, 3201);
    chk("line_second", second, 6401);
    chk("line_wide", wide, 0);
    chk("hsync_low_clks", hs_low, 384);

    // Decode vectors: outputs reflect (h, v) one clock after h_count shows h.
    for (int i = 0; i < 16; i++) begin
      vc   = tbl[i].v;
      prev = (tbl[i].h == 10'd0) ? 10'd799 : tbl[i].h - 10'd1;
      wait_tick_at(prev, "vec_wait");
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_h", i), hc, tbl[i].h);
      chk($sformatf("vec%0d_hs", i), hs, tbl[i].hs);
      chk($sformatf("vec%0d_vs", i), vs, tbl[i].vs);
      chk($sformatf("vec%0d_von", i), von, tbl[i].von);
      chk($sformatf("vec%0d_px", i), px, tbl[i].px);
      chk($sformatf("vec%0d_py", i), py, tbl[i].py);
    end

    // Reset mid-line at h_count=700, two clocks into the divider period.
    vc = 10'd100;
    wait_tick_at(10'd699, "mid_wait");
    @(negedge clk);
    @(negedge clk);
    chk("mid_pre_h", hc, 700);
    chk("mid_pre_hs", hs, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_h", hc, 0);
    chk("mid_hs", hs, 1);
    chk("mid_le", le, 0);
    chk("mid_tick", tick, 0);
    chk("mid_von", von, 0);
    check_restart("mid");

    // Active-high syncs, PIX_DIV=2, vsync window line 490.
    chk("pol_rst_hs", hs_p, 0);
    chk("pol_rst_vs", vs_p, 0);
    chk("pol_rst_tick", tick_p, 0);
    rst_p   = 1'b0;
    first   = 0;
    second  = 0;
    hs_low  = 0;
    wide    = 0;
    le_prev = le_p;
    for (int k = 1; k <= 3202; k++) begin
      @(negedge clk);
      if (k <= 8) chk("pol_tick", tick_p, (k % 2 == 0));
      if (k == 2) chk("pol_vs", vs_p, 1);
      if (k == 1600) chk("pol_h799", hc_p, 799);
      if (le_p && !le_prev) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (le_p && le_prev) wide++;
      if (k >= 1601 && k <= 3200 && hs_p) hs_low++;
      le_prev = le_p;
    end
    chk("pol_first", first, 1601);
    chk("pol_second", second, 3201);
    chk("pol_wide", wide, 0);
    chk("pol_hs_high_clks", hs_low, 192);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_hsync_timing.md
Name: vga_hsync_timing

Overview:
- Horizontal timing stage of the VGA controller. Divides the system clock into a pixel-rate tick and runs the horizontal pixel counter.
- Emits a one-cycle line_end pulse that enables the downstream vertical line counter.
- Combines its horizontal count with the returned vertical count to drive hsync, vsync, video_on and pixel coordinates to the pixel generator and the VGA pins.

Parameters:
- PIX_DIV, 4, system clocks per pixel (>=2)
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- Clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- v_count  in  10  current line number from the vertical counter, sampled every Clk
- pix_tick  out  1  one-Clk pulse per pixel period
- h_count  out  10  horizontal pixel counter, 0..H_TOTAL-1
- line_end  out  1  one-Clk pulse, vertical counter clock enable
- hsync  out  1  horizontal sync to pin
- vsync  out  1  vertical sync to pin
- video_on  out  1  high inside the visible window
- pixel_x  out  10  visible column, 0 outside the window
- pixel_y  out  10  visible row, 0 outside the window

Behaviour:
Reset:
- Applies on any Clk edge with reset=1, including mid-line; it overrides everything.
- div=0, h_count=0, pix_tick=0, line_end=0, video_on=0, pixel_x=0, pixel_y=0.
- hsync=vsync=~SYNC_POL (inactive).

Pixel divider:
- div counts 0..PIX_DIV-1 and wraps.
- pix_tick is registered: high for the one Clk following the edge where div==PIX_DIV-1.
- Period is exactly PIX_DIV Clks.

Horizontal counter:
- Advances only in cycles where pix_tick=1.
- h_count==H_TOTAL-1 -> 0 (wrap); otherwise h_count+1.
- Holds its value on all other Clks.

line_end:
- Registered; high for exactly one Clk, the cycle immediately after h_count wraps to 0.
- One pulse per H_TOTAL*PIX_DIV Clks.
- Never asserted during reset or in the first cycle after reset.

Decode:
- All registered, one-Clk latency from h_count and the sampled v_count.
- hsync active when H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync active when V_DISPLAY+V_FRONT <= v_count < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY).
- pixel_x = h_count and pixel_y = v_count when video_on, else both 0, registered in the same cycle as video_on.

Width and range rules:
- Comparisons are unsigned, 10-bit.
- v_count values >= V_DISPLAY+V_FRONT+V_SYNC give vsync inactive and video_on=0; no error signalling.
- The block does not wrap or check v_count.

Simultaneous events:
- reset together with a div wrap: reset wins, and neither pix_tick nor line_end is emitted.
- v_count changing in the same Clk as line_end: the new value is reflected in the decode outputs one Clk later.

Test Plan:
- Reset check: hold reset 3 Clks, release. Required: pix_tick first high on Clk 4 after release; then exactly every 4 Clks; h_count 0->1 on the Clk after the first pix_tick.
- Line period: drive v_count=0 and run 3200 Clks past the first tick. Required: h_count reaches 799 then wraps to 0; exactly one line_end pulse, one Clk wide; successive line_end rising edges 3200 Clks apart.
- hsync window: v_count=100. Required: hsync=0 exactly while the registered h_count is in 656..751 (96 pixels = 384 Clks low); hsync=1 elsewhere. video_on=1 only for h_count 0..639, with pixel_x tracking h_count and pixel_y=100.
- vsync and blanking: sweep v_count 479, 480, 490, 491, 492, 524. Required:
  - video_on=0 for all v_count >= 480;
  - vsync=0 only for 490 and 491;
  - pixel_x = pixel_y = 0 whenever video_on=0.
- Reset mid-operation: assert reset for 1 Clk at h_count=700, 2 Clks into a divider period. Required: next Clk shows h_count=0, hsync=1, line_end=0, pix_tick=0; timing restarts identically to power-up.
- Polarity and parameters: SYNC_POL=1, PIX_DIV=2. Required: hsync/vsync high in their windows and low at reset; pix_tick every 2 Clks; line_end period 1600 Clks.
